// File: rtl/tt_cell_link_host.sv
// rtl/tt_cell_link_host.sv - host side of a clocked serial link to a cell register file
//
// Frames one register access per request onto a clock pad (hclk) and a
// bidirectional data pad (hsig). Each bit lasts 2*CLK_DIV clk cycles: hclk
// is low for the first half and high for the second half. Driven bits change
// at the start of the low half. Read bits are sampled on the first high cycle.
//
//   write: start(0) rw addr[5:0] wdata[7:0] [par] stop(1)
//   read : start(0) rw addr[5:0] turn rdata[7:0] [par] stop(1)
//
// Optional feature macro: TT_CELL_LINK_PARITY_EN adds an even parity bit
// after the data field (host-driven on writes, checked on reads).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_rw, req_addr, req_wdata request fields, 1 = read
//   done                       one-cycle pulse on return to IDLE
//   rdata                      last completed read value
//   err                        read parity error, qualified by done
//   hclk_A, hclk_OE            link clock pad drive / enable
//   hsig_A, hsig_OE, hsig_IE, hsig_PU, hsig_PD  link data pad controls
//   hsig_Y                     link data pad input

module tt_cell_link_host #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       err,
    output logic       hclk_A,
    output logic       hclk_OE,
    output logic       hsig_A,
    output logic       hsig_OE,
    output logic       hsig_IE,
    output logic       hsig_PU,
    output logic       hsig_PD,
    input  logic       hsig_Y
);

`ifdef TT_CELL_LINK_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, HDR, WDATA, TURN, RDATA, PAR, STOP} state_t;
    localparam state_t DATA_NEXT = PAR;
`else
    typedef enum logic [2:0] {IDLE, START, HDR, WDATA, TURN, RDATA, STOP} state_t;
    localparam state_t DATA_NEXT = STOP;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state, state_n;
    logic [7:0] div_cnt;
    logic       phase;          // 0 = hclk low half, 1 = hclk high half
    logic [2:0] bit_cnt;        // bit index within the current field
    logic       rw_q;
    logic [5:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rsh;
    logic [6:0] hdr;
    logic       bit_end;
    logic       sample_en;

    assign hdr       = {rw_q, addr_q};
    assign bit_end   = phase && (div_cnt == DIV_LAST);
    assign sample_en = phase && (div_cnt == 8'd0);

    assign hclk_A  = phase;
    assign hclk_OE = 1'b1;
    assign hsig_IE = 1'b1;
    assign hsig_PU = 1'b1;
    assign hsig_PD = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        hsig_A    = 1'b1;
        hsig_OE   = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = START;
            end
            START: begin
                hsig_A = 1'b0;
                if (bit_end) state_n = HDR;
            end
            HDR: begin
                hsig_A = hdr[3'd6 - bit_cnt];
                if (bit_end && bit_cnt == 3'd6) state_n = rw_q ? TURN : WDATA;
            end
            WDATA: begin
                hsig_A = wdata_q[3'd7 - bit_cnt];
                if (bit_end && bit_cnt == 3'd7) state_n = DATA_NEXT;
            end
            TURN: begin
                hsig_OE = 1'b0;
                if (bit_end) state_n = RDATA;
            end
            RDATA: begin
                hsig_OE = 1'b0;
                if (bit_end && bit_cnt == 3'd7) state_n = DATA_NEXT;
            end
`ifdef TT_CELL_LINK_PARITY_EN
            PAR: begin
                if (rw_q) hsig_OE = 1'b0;
                else      hsig_A  = ^{rw_q, addr_q, wdata_q};
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef TT_CELL_LINK_PARITY_EN
    logic err_q;
    logic par_rx;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= 8'd0;
            phase   <= 1'b0;
            bit_cnt <= 3'd0;
            rw_q    <= 1'b0;
            addr_q  <= 6'd0;
            wdata_q <= 8'd0;
            rsh     <= 8'd0;
            done    <= 1'b0;
            rdata   <= 8'd0;
`ifdef TT_CELL_LINK_PARITY_EN
            err_q   <= 1'b0;
            par_rx  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                div_cnt <= 8'd0;
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                if (req_valid) begin
                    rw_q    <= req_rw;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                end
            end else begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= 8'd0;
                    phase   <= ~phase;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
                // Field-relative bit index restarts whenever the state changes.
                if (bit_end) bit_cnt <= (state_n != state) ? 3'd0 : bit_cnt + 3'd1;
                if (sample_en && state == RDATA) rsh <= {rsh[6:0], hsig_Y};
`ifdef TT_CELL_LINK_PARITY_EN
                if (sample_en && state == PAR) par_rx <= hsig_Y;
`endif
                if (bit_end && state == STOP) begin
                    done <= 1'b1;
                    if (rw_q) rdata <= rsh;
`ifdef TT_CELL_LINK_PARITY_EN
                    err_q <= rw_q & (par_rx ^ (^rsh));
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_cell_link_host.sv
// tb/tb_tt_cell_link_host.sv - scoreboard bench for tt_cell_link_host
module tb_tt_cell_link_host;

`ifdef TT_CELL_LINK_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_req_valid, a_req_ready, a_req_rw, a_done, a_err;
    logic [5:0] a_req_addr;
    logic [7:0] a_req_wdata, a_rdata;
    logic       a_hclk_A, a_hclk_OE, a_hsig_A, a_hsig_OE, a_hsig_IE, a_hsig_PU, a_hsig_PD;
    logic       a_hsig_Y = 1'b1;

    logic       b_req_valid, b_req_ready, b_done, b_err;
    logic       b_req_rw = 1'b0;
    logic [5:0] b_req_addr;
    logic [7:0] b_req_wdata, b_rdata;
    logic       b_hclk_A, b_hclk_OE, b_hsig_A, b_hsig_OE, b_hsig_IE, b_hsig_PU, b_hsig_PD;
    logic       b_hsig_Y = 1'b1;

    tt_cell_link_host #(.CLK_DIV(2)) u_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_rw(a_req_rw), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .done(a_done), .rdata(a_rdata), .err(a_err), .hclk_A(a_hclk_A), .hclk_OE(a_hclk_OE),
        .hsig_A(a_hsig_A), .hsig_OE(a_hsig_OE), .hsig_IE(a_hsig_IE), .hsig_PU(a_hsig_PU),
        .hsig_PD(a_hsig_PD), .hsig_Y(a_hsig_Y)
    );

    tt_cell_link_host #(.CLK_DIV(255)) u_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_rw(b_req_rw), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .done(b_done), .rdata(b_rdata), .err(b_err), .hclk_A(b_hclk_A), .hclk_OE(b_hclk_OE),
        .hsig_A(b_hsig_A), .hsig_OE(b_hsig_OE), .hsig_IE(b_hsig_IE), .hsig_PU(b_hsig_PU),
        .hsig_PD(b_hsig_PD), .hsig_Y(b_hsig_Y)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit        rw;
        bit [18:0] seq;
        int        nbits;
        int        lat;
        bit [7:0]  rdata;
        bit        err;
    } exp_t;

    exp_t     q[$];
    int       bq[$];
    bit [7:0] last_rd = 8'h00;

    // Cell model: drives read bits (and parity) while the host releases hsig.
    logic [7:0] rd_val = 8'h00;
    logic       rd_par = 1'b0;
    int         idx = 0;
    logic       m_prev_h = 1'b0, m_prev_oe = 1'b1;
    always @(negedge clk) begin
        if (!a_hsig_OE && m_prev_oe) idx = 0;
        else if (!a_hsig_OE && !a_hclk_A && m_prev_h) idx = idx + 1;
        m_prev_h  = a_hclk_A;
        m_prev_oe = a_hsig_OE;
        if (!a_hsig_OE && idx >= 1 && idx <= 8) a_hsig_Y = rd_val[8 - idx];
        else if (!a_hsig_OE && idx == 9)        a_hsig_Y = rd_par;
        else                                    a_hsig_Y = 1'b1;
    end

    // Monitor for the CLK_DIV=2 instance.
    exp_t       e;
    int         acc_cyc = 0, nb = 0, oe_low = 0, ready_viol = 0, hchg = 0;
    logic [18:0] seq = '0;
    logic       prev_h = 1'b0, prev_a = 1'b1;
    bit         in_frame = 0, exp_start = 0;
    always @(negedge clk) begin
        if (exp_start) begin
            check("b2b_start_hsig_A", 32'(a_hsig_A), 32'd0);
            check("b2b_start_ready", 32'(a_req_ready), 32'd0);
            exp_start = 0;
        end
        if (rst) begin
            in_frame = 0;
        end else begin
            if (a_hclk_A && !prev_h) begin
                seq = {seq[17:0], a_hsig_A};
                nb++;
                if (!a_hsig_OE) oe_low++;
            end
            if (a_hclk_A && prev_h && a_hsig_A !== prev_a) hchg++;
            if (in_frame && !a_done && a_req_ready) ready_viol++;
            if (a_done) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: actual=done expected=no done at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    check("bit_count", 32'(nb), 32'(e.nbits));
                    check("ready_low_in_frame", 32'(ready_viol), 32'd0);
                    check("hsig_stable_while_hclk_high", 32'(hchg), 32'd0);
                    check("rdata", 32'(a_rdata), 32'(e.rdata));
                    check("err", 32'(a_err), 32'(e.err));
                    if (e.rw) check("oe_low_bits", 32'(oe_low), 32'(9 + PB));
                    else      check("hsig_A_sequence", 32'(seq), 32'(e.seq));
                end
                in_frame = 0;
                if (a_req_valid) exp_start = 1;
            end
            if (a_req_valid && a_req_ready) begin
                acc_cyc = cyc + 1;
                nb = 0; oe_low = 0; ready_viol = 0; hchg = 0; seq = '0;
                in_frame = 1;
            end
        end
        prev_h = a_hclk_A;
        prev_a = a_hsig_A;
    end

    // Monitor for the CLK_DIV=255 instance: phase lengths and bit count.
    int   b_acc = 0, b_run = 0, b_rises = 0, hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
    logic b_prev_h = 1'b0;
    bit   b_in = 0;
    always @(negedge clk) begin
        if (b_in) begin
            if (b_hclk_A == b_prev_h) begin
                b_run++;
            end else begin
                if (b_prev_h) begin
                    if (b_run < hi_min) hi_min = b_run;
                    if (b_run > hi_max) hi_max = b_run;
                end else begin
                    if (b_run < lo_min) lo_min = b_run;
                    if (b_run > lo_max) lo_max = b_run;
                end
                b_run = 1;
                if (b_hclk_A) b_rises++;
            end
        end
        if (b_done) begin
            if (bq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL b_unexpected_done: actual=done expected=no done at cycle %0d", cyc);
            end else begin
                check("b_latency", 32'(cyc - b_acc), 32'(bq.pop_front()));
                check("b_bits", 32'(b_rises), 32'(17 + PB));
                check("b_high_min", 32'(hi_min), 32'd255);
                check("b_high_max", 32'(hi_max), 32'd255);
                check("b_low_min", 32'(lo_min), 32'd255);
                check("b_low_max", 32'(lo_max), 32'd255);
                check("b_err", 32'(b_err), 32'd0);
            end
            b_in = 0;
        end
        if (b_req_valid && b_req_ready && !rst) begin
            b_in = 1; b_run = 0; b_rises = 0;
            hi_min = 9999; lo_min = 9999; hi_max = 0; lo_max = 0;
            b_acc = cyc + 1;
        end
        b_prev_h = b_hclk_A;
    end

    task automatic a_push(input bit rw, input bit [16:0] lit, input bit [7:0] rv, input bit eerr);
        exp_t x;
        x.rw    = rw;
        x.nbits = (rw ? 18 : 17) + PB;
        x.lat   = 4 * x.nbits;
        x.err   = eerr;
        x.seq   = (PB == 1) ? {1'b0, lit[16:1], ^lit[15:1], 1'b1} : {2'b00, lit};
        if (rw) last_rd = rv;
        x.rdata = last_rd;
        q.push_back(x);
    endtask

    task automatic wait_accept(input bit use_b);
        bit got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (use_b ? b_req_ready : a_req_ready) got = 1;
        end
        check("accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit use_b, input int limit);
        bit got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (use_b ? b_done : a_done) got = 1;
        end
        check("done_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic a_xfer(input bit rw, input bit [5:0] addr, input bit [7:0] wd,
                          input bit [16:0] lit, input bit [7:0] rv, input bit rp, input bit eerr);
        a_push(rw, lit, rv, eerr);
        rd_val = rv;
        rd_par = rp;
        a_req_rw = rw; a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1;
        wait_accept(1'b0);
        a_req_valid = 1'b0;
        wait_done(1'b0, 600);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=still running expected=finished");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_rw = 1'b0; a_req_addr = 6'h00; a_req_wdata = 8'h00;
        b_req_valid = 1'b0; b_req_addr = 6'h00; b_req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_rdata", 32'(a_rdata), 32'h00);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_hclk_A", 32'(a_hclk_A), 32'd0);
        check("rst_hsig_A", 32'(a_hsig_A), 32'd1);
        check("rst_hsig_OE", 32'(a_hsig_OE), 32'd1);
        check("rst_pads", 32'({a_hclk_OE, a_hsig_IE, a_hsig_PU, a_hsig_PD}), 32'b1110);
        @(posedge clk);
        #1;

        a_xfer(1'b0, 6'h15, 8'hA5, 17'b0_0_010101_10100101_1, 8'h00, 1'b0, 1'b0);
        a_xfer(1'b1, 6'h3F, 8'h00, 17'h0, 8'h5C, 1'b0, 1'b0);
        a_xfer(1'b0, 6'h2A, 8'h3C, 17'b0_0_101010_00111100_1, 8'h00, 1'b0, 1'b0);
        a_xfer(1'b1, 6'h00, 8'h00, 17'h0, 8'hFF, 1'b0, 1'b0);

        // Reset in the middle of the write data field.
        a_req_rw = 1'b0; a_req_addr = 6'h15; a_req_wdata = 8'hA5; a_req_valid = 1'b1;
        wait_accept(1'b0);
        a_req_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rd = 8'h00;
        @(negedge clk);
        check("midrst_req_ready", 32'(a_req_ready), 32'd1);
        check("midrst_hsig_A", 32'(a_hsig_A), 32'd1);
        check("midrst_hclk_A", 32'(a_hclk_A), 32'd0);
        check("midrst_done", 32'(a_done), 32'd0);
        check("midrst_rdata", 32'(a_rdata), 32'h00);
        repeat (150) @(posedge clk);
        #1;
        a_xfer(1'b0, 6'h15, 8'hA5, 17'b0_0_010101_10100101_1, 8'h00, 1'b0, 1'b0);

        // Two writes with req_valid held high across the first done.
        a_push(1'b0, 17'b0_0_000001_10000000_1, 8'h00, 1'b0);
        a_push(1'b0, 17'b0_0_111110_01111111_1, 8'h00, 1'b0);
        a_req_rw = 1'b0; a_req_addr = 6'h01; a_req_wdata = 8'h80; a_req_valid = 1'b1;
        wait_accept(1'b0);
        a_req_addr = 6'h3E; a_req_wdata = 8'h7F;
        wait_done(1'b0, 600);
        a_req_valid = 1'b0;
        wait_done(1'b0, 600);

`ifdef TT_CELL_LINK_PARITY_EN
        a_xfer(1'b1, 6'h07, 8'h00, 17'h0, 8'h01, 1'b0, 1'b1);
        a_xfer(1'b1, 6'h07, 8'h00, 17'h0, 8'h01, 1'b1, 1'b0);
`endif

        bq.push_back(510 * (17 + PB));
        b_req_addr = 6'h15; b_req_wdata = 8'hA5; b_req_valid = 1'b1;
        wait_accept(1'b1);
        b_req_valid = 1'b0;
        wait_done(1'b1, 10000);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(q.size() + bq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
